label_window_gen: RTL
=====================

Name: label_window_gen

Overview:
- Neighbourhood generator directly upstream of connected_components_labeling.
- Takes the binary pixel stream in raster order and tracks x/y internally.
- Holds the previous row of resolved labels (written back from the labeler's q output) and presents one {A, B, C, D, p, x, y} window per pixel.
- Strictly in-order: issues one pixel, waits for that pixel's label write-back, then accepts the next.

Parameters:
IMG_WIDTH, 640, pixels per row; ≥2.
IMG_HEIGHT, 480, rows per frame; ≥1.
Label width is `LBL_WIDTH and coordinate width is `LOC_SIZE, both from global.vh; neither is a parameter.

Ports:
clk  in  1  clock; all logic on posedge.
reset  in  1  asynchronous, active-high reset.
pix_valid  in  1  pixel offered.
pix_ready  out  1  block can accept a pixel.
pix  in  1  binary foreground bit.
pix_sof  in  1  with pix_valid: this pixel is (0,0) of a new frame.
win_valid  out  1  one-cycle pulse; drives the labeler's en.
win_A  out  `LBL_WIDTH  label at (x-1, y-1).
win_B  out  `LBL_WIDTH  label at (x, y-1).
win_C  out  `LBL_WIDTH  label at (x+1, y-1).
win_D  out  `LBL_WIDTH  label at (x-1, y).
win_p  out  1  registered pix.
win_x  out  `LOC_SIZE  column.
win_y  out  `LOC_SIZE  row.
wb_valid  in  1  labeler's q is valid for the last issued pixel.
wb_label  in  `LBL_WIDTH  resolved label q.
eof  out  1  one-cycle pulse when the window for (IMG_WIDTH-1, IMG_HEIGHT-1) is written back.
wb_err  out  1  sticky flag: wb_valid seen outside WAIT.

Behaviour:
- Reset (async, on assertion): all outputs 0, pix_ready 0, state PRIME, x=y=0, a/b/c/d holding regs 0. The row buffer is not cleared; y=0 masking makes its contents irrelevant.
- Row buffer: IMG_WIDTH × `LBL_WIDTH, one synchronous-read port plus one write port. A read issued in cycle n returns data in cycle n+1.
- States:
  - PRIME: row start only. Read row[0] (1 cycle), then row[1] (1 cycle). Load b_reg = row[0], c_reg = row[1]. Go to IDLE.
  - IDLE: pix_ready=1. On pix_valid: latch pix; if pix_sof, force x=y=0. Go to ISSUE.
  - ISSUE: win_valid=1 for exactly one cycle. Window fields:
    - A = a_reg, B = b_reg, C = c_reg, D = d_reg.
    - Masking, applied combinationally at output: y=0 forces A=B=C=0; x=0 forces A=D=0; x=IMG_WIDTH-1 forces C=0.
    - Go to WAIT.
  - WAIT: pix_ready=0. No timeout; hold until wb_valid.
    - On wb_valid: row[x] <= wb_label; d_reg <= wb_label.
    - If x < IMG_WIDTH-1: a_reg <= b_reg, b_reg <= c_reg, issue read row[x+2] (skip if x+2 ≥ IMG_WIDTH), x++. Go to FETCH.
    - Else: x=0, d_reg=0, y++. Go to PRIME.
    - If additionally y = IMG_HEIGHT-1: pulse eof, wrap y=0, go to PRIME.
  - FETCH: c_reg <= read data (0 if out of range). Go to IDLE.
- Overwrite ordering: because a_reg/b_reg/c_reg capture the previous-row values before row[x] is rewritten, A/B/C always come from row y-1 and D from row y.
- Throughput: one pixel per (labeler latency + 3) cycles.
- Every foreground and background pixel must receive a write-back; background write-back is label 0.
- Simultaneous pix_sof mid-frame: honoured. Coordinates restart at (0,0); row-buffer contents are stale but masked at y=0.
- wb_valid in any state other than WAIT: ignored; sets wb_err, cleared only by reset.
- Reset mid-WAIT: return to PRIME; the pending write-back is discarded.

Optional Feature:
- Macro: LABEL_WINDOW_8CONN_EN.
- Defined: 8-connectivity; A and C as above.
- Undefined: 4-connectivity; win_A and win_C tied to 0 and the a_reg/c_reg fetch logic removed. B and D unchanged.

Test Plan:
1. Reset then idle for 10 cycles -> pix_ready=1 only after PRIME (3rd cycle post-reset); all win_* = 0; win_valid never pulses.
2. IMG_WIDTH=4, row 0 pixels 1,1,0,1, write-back labels 1,1,0,2 -> each window A=B=C=0; D sequence 0,1,1,0; x 0..3, y=0.
3. Row 1 after test 2, all pixels 1, write-back 1,1,1,1 -> windows (A,B,C,D) = (0,1,1,0), (1,1,0,1), (1,0,2,1), (0,2,0,1).
4. Last pixel of a 4×2 frame written back -> eof pulses exactly 1 cycle; next window has x=y=0.
5. wb_valid asserted during IDLE -> wb_err=1, state and row buffer unchanged; wb_err stays 1 until reset.
6. Build without LABEL_WINDOW_8CONN_EN, rerun test 3 -> win_A=win_C=0 on every window; B and D unchanged.

Source files
------------

// File: rtl/label_window_gen.sv
// label_window_gen: raster-order neighbourhood generator feeding the
// connected-components labeler. One pixel in flight at a time.
//   clk, reset (async, active-high)
//   pix_valid/pix_ready/pix/pix_sof : binary pixel stream in
//   win_valid, win_A..win_D, win_p, win_x, win_y : window out
//   wb_valid/wb_label : resolved label write-back from the labeler
//   eof : frame-done pulse, wb_err : sticky stray write-back flag
// LABEL_WINDOW_8CONN_EN defined: 8-connectivity (A and C live);
// undefined: 4-connectivity (A and C tied to 0).

`ifndef LBL_WIDTH
`define LBL_WIDTH 8
`endif
`ifndef LOC_SIZE
`define LOC_SIZE 10
`endif

module label_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic                  pix,
  input  logic                  pix_sof,
  output logic                  win_valid,
  output logic [`LBL_WIDTH-1:0] win_A,
  output logic [`LBL_WIDTH-1:0] win_B,
  output logic [`LBL_WIDTH-1:0] win_C,
  output logic [`LBL_WIDTH-1:0] win_D,
  output logic                  win_p,
  output logic [`LOC_SIZE-1:0]  win_x,
  output logic [`LOC_SIZE-1:0]  win_y,
  input  logic                  wb_valid,
  input  logic [`LBL_WIDTH-1:0] wb_label,
  output logic                  eof,
  output logic                  wb_err
);

  localparam int LW = `LBL_WIDTH;
  localparam int LS = `LOC_SIZE;
  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [LS-1:0] X_LAST = LS'(IMG_WIDTH - 1);
  localparam logic [LS-1:0] Y_LAST = LS'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_PRIME, S_IDLE, S_ISSUE, S_WAIT, S_FETCH
  } state_t;

  state_t          state, nxt;
  logic [LS-1:0]   x, y;
  logic [LW-1:0]   b_reg, d_reg;
  logic            p_reg;
  logic            prime_cnt;
  logic            x_last, y_last;
  logic            wb_take;

  logic [LW-1:0]   row_mem [IMG_WIDTH];
  logic [LW-1:0]   rd_data;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;

`ifdef LABEL_WINDOW_8CONN_EN
  logic [LW-1:0]   a_reg, c_reg;
  logic            c_load;
  logic            oob;
  logic [LS:0]     nx2;
  logic            nx2_oob;
`endif

  assign x_last  = (x == X_LAST);
  assign y_last  = (y == Y_LAST);
  assign wb_take = (state == S_WAIT) && wb_valid;

`ifdef LABEL_WINDOW_8CONN_EN
  assign nx2     = {1'b0, x} + (LS+1)'(2);
  assign nx2_oob = (nx2 >= (LS+1)'(IMG_WIDTH));
`endif

  // Row buffer: one sync-read port, one write port.
  always_ff @(posedge clk) begin
    if (wb_take)
      row_mem[AW'(x)] <= wb_label;
    if (rd_en)
      rd_data <= row_mem[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_PRIME;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_PRIME: if (prime_cnt) nxt = S_IDLE;
      S_IDLE:  if (pix_valid) nxt = S_ISSUE;
      S_ISSUE: nxt = S_WAIT;
      S_WAIT:  if (wb_valid)
                 nxt = x_last ? S_PRIME : S_FETCH;
      S_FETCH: nxt = S_IDLE;
      default: nxt = S_PRIME;
    endcase
  end

  // Row-buffer read requests.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    unique case (1'b1)
      state == S_PRIME: begin
`ifdef LABEL_WINDOW_8CONN_EN
        rd_en   = 1'b1;
        rd_addr = prime_cnt ? AW'(1) : '0;
`else
        rd_en   = !prime_cnt;
`endif
      end
      wb_take && !x_last: begin
`ifdef LABEL_WINDOW_8CONN_EN
        rd_en   = !nx2_oob;
        rd_addr = AW'(nx2);
`else
        rd_en   = 1'b1;
        rd_addr = AW'(x + 1'b1);
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    pix_ready = (state == S_IDLE);
    win_valid = (state == S_ISSUE);
    win_B     = (y == '0) ? '0 : b_reg;
    win_D     = (x == '0) ? '0 : d_reg;
`ifdef LABEL_WINDOW_8CONN_EN
    win_A     = (y == '0 || x == '0) ? '0 : a_reg;
    win_C     = (y == '0 || x_last) ? '0 : c_reg;
`else
    win_A     = '0;
    win_C     = '0;
`endif
    win_p     = p_reg;
    win_x     = x;
    win_y     = y;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      b_reg     <= '0;
      d_reg     <= '0;
      p_reg     <= 1'b0;
      prime_cnt <= 1'b0;
      eof       <= 1'b0;
      wb_err    <= 1'b0;
`ifdef LABEL_WINDOW_8CONN_EN
      a_reg     <= '0;
      c_reg     <= '0;
      c_load    <= 1'b0;
      oob       <= 1'b0;
`endif
    end else begin
      eof <= 1'b0;
      if (wb_valid && state != S_WAIT)
        wb_err <= 1'b1;
      unique case (state)
        S_PRIME: begin
          prime_cnt <= ~prime_cnt;
          if (prime_cnt) begin
            b_reg  <= rd_data;
`ifdef LABEL_WINDOW_8CONN_EN
            // row[1] lands during the first IDLE cycle
            c_load <= 1'b1;
`endif
          end
        end
        S_IDLE: begin
`ifdef LABEL_WINDOW_8CONN_EN
          if (c_load) begin
            c_reg  <= rd_data;
            c_load <= 1'b0;
          end
`endif
          if (pix_valid) begin
            p_reg <= pix;
            if (pix_sof) begin
              x <= '0;
              y <= '0;
            end
          end
        end
        S_WAIT: begin
          if (wb_valid) begin
            if (!x_last) begin
              d_reg <= wb_label;
              x     <= x + 1'b1;
`ifdef LABEL_WINDOW_8CONN_EN
              a_reg <= b_reg;
              b_reg <= c_reg;
              oob   <= nx2_oob;
`endif
            end else begin
              d_reg <= '0;
              x     <= '0;
              if (y_last) begin
                y   <= '0;
                eof <= 1'b1;
              end else begin
                y   <= y + 1'b1;
              end
            end
          end
        end
        S_FETCH: begin
`ifdef LABEL_WINDOW_8CONN_EN
          c_reg <= oob ? '0 : rd_data;
`else
          b_reg <= rd_data;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
